game_flow_ctrl: RTL and testbench

Top-level sequencer for the runner game's obstacle datapath. Owns game state (idle/clear/run/over) and generates the game-step tick that the obstacle/score controller consumes. Issues that controller's synchronous clear and freeze (over) signals. Sets the difficulty: tick period and minimum obstacle spacing both tighten as the BCD score grows.

---
 rtl/game_flow_ctrl.sv | 173 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game state sequencer for the runner game: start/restart handling, game-step tick and difficulty.
// Defining PAUSE_EN adds a pause_btn input and a PAUSE state (state output widens to 3 bits).
module game_flow_ctrl #(
  parameter int DIV_W          = 20,
  parameter int BASE_DIV       = 400000,
  parameter int DIV_STEP       = 40000,
  parameter int MAX_LEVEL      = 7,
  parameter int MIN_EMPTY_BASE = 300,
  parameter int MIN_EMPTY_STEP = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
`ifdef PAUSE_EN
  input  logic        pause_btn,
`endif
  input  logic        collide,
  input  logic [15:0] score,
  output logic        game_tick,
  output logic        game_rst,
  output logic        over,
  output logic [8:0]  min_empty,
  output logic [2:0]  level,
`ifdef PAUSE_EN
  output logic [2:0]  state
`else
  output logic [1:0]  state
`endif
);

`ifdef PAUSE_EN
  localparam int STATE_W = 3;
`else
  localparam int STATE_W = 2;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = STATE_W'(0),
    S_CLEAR = STATE_W'(1),
    S_RUN   = STATE_W'(2),
`ifdef PAUSE_EN
    S_OVER  = STATE_W'(3),
    S_PAUSE = STATE_W'(4)
`else
    S_OVER  = STATE_W'(3)
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_vld;
  logic             btn_s1, btn_s2, btn_prev, press;
  logic             clr_last, run_stay;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       level_q, level_d;
  logic [3:0]       hund_q, hund_d;
  logic             tick_q, tick_d;
  logic [8:0]       min_empty_q;
  logic             unused_score;

  assign unused_score = ^{score[15:12], score[7:0]};

  function automatic logic [DIV_W-1:0] period_m1(input logic [2:0] lv);
    period_m1 = DIV_W'(BASE_DIV - int'(lv) * DIV_STEP - 1);
  endfunction

  // sync_vld qualifies the edge detector until the synchronizer holds real samples,
  // so a button held through reset release is not seen as a press.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      sync_vld <= '0;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[1:0], 1'b1};
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign press = sync_vld[2] & btn_s2 & ~btn_prev;

`ifdef PAUSE_EN
  logic pb_s1, pb_s2, pb_prev, pause_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pb_s1   <= 1'b0;
      pb_s2   <= 1'b0;
      pb_prev <= 1'b0;
    end else begin
      pb_s1   <= pause_btn;
      pb_s2   <= pb_s1;
      pb_prev <= pb_s2;
    end
  end

  assign pause_press = sync_vld[2] & pb_s2 & ~pb_prev;
`endif

  always_comb begin
    // NOTE: defaults come first so every path assigns every variable and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (press) state_d = S_CLEAR;
      S_CLEAR: if (clr_last) state_d = S_RUN;
`ifdef PAUSE_EN
      S_RUN: begin
        if (collide)          state_d = S_OVER;
        else if (pause_press) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (press)            state_d = S_CLEAR;
        else if (pause_press) state_d = S_RUN;
      end
`else
      S_RUN:   if (collide) state_d = S_OVER;
`endif
      S_OVER:  if (press) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  // The divider only advances while RUN persists, so leaving RUN freezes it without losing a tick.
  always_comb begin
    run_stay = (state_q == S_RUN) && (state_d == S_RUN);
    tick_d   = (state_d == S_CLEAR) || (run_stay && div_q == '0);
    div_d    = div_q;
    level_d  = level_q;
    hund_d   = hund_q;
    if (state_d == S_CLEAR) begin
      div_d   = period_m1(3'd0);
      level_d = 3'd0;
    end else if (run_stay) begin
      div_d = (div_q == '0) ? period_m1(level_q) : div_q - DIV_W'(1);
    end
    if (state_q == S_RUN && !collide && score[11:8] != hund_q && int'(level_q) < MAX_LEVEL)
      level_d = level_q + 3'd1;
    // Priming in CLEAR keeps the first RUN cycle from comparing against the previous game's score.
    if (state_q == S_CLEAR || state_q == S_RUN)
      hund_d = score[11:8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      clr_last    <= 1'b0;
      div_q       <= period_m1(3'd0);
      level_q     <= 3'd0;
      hund_q      <= 4'd0;
      tick_q      <= 1'b0;
      min_empty_q <= 9'(MIN_EMPTY_BASE);
    end else begin
      state_q     <= state_d;
      clr_last    <= (state_q == S_CLEAR);
      div_q       <= div_d;
      level_q     <= level_d;
      hund_q      <= hund_d;
      tick_q      <= tick_d;
      min_empty_q <= 9'(10'(MIN_EMPTY_BASE - int'(level_q) * MIN_EMPTY_STEP));
    end
  end

  assign state     = state_q;
  assign game_tick = tick_q;
  assign game_rst  = (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign over      = (state_q == S_OVER);
  assign level     = level_q;
  assign min_empty = min_empty_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed game sequence with randomized scores and
// collision timing, compared each cycle against an event-level model of the game rules.
module tb_game_flow_ctrl;
  localparam int BASE_DIV  = 10;
  localparam int DIV_STEP  = 1;
  localparam int MAX_LEVEL = 7;
  localparam int ME_BASE   = 300;
  localparam int ME_STEP   = 20;
  localparam int IDLE = 0, CLEAR = 1, RUN = 2, OVER = 3;

  logic        clk = 1'b0;
  logic        rst, btn, collide;
  logic [15:0] score;
  logic        game_tick, game_rst, over;
  logic [8:0]  min_empty;
  logic [2:0]  level;
`ifdef PAUSE_EN
  logic        pause_btn = 1'b0;
  logic [2:0]  state;
`else
  logic [1:0]  state;
`endif

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .DIV_W(20), .BASE_DIV(BASE_DIV), .DIV_STEP(DIV_STEP), .MAX_LEVEL(MAX_LEVEL),
    .MIN_EMPTY_BASE(ME_BASE), .MIN_EMPTY_STEP(ME_STEP)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
`ifdef PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .collide(collide), .score(score), .game_tick(game_tick), .game_rst(game_rst),
    .over(over), .min_empty(min_empty), .level(level), .state(state)
  );

  int n_vec, n_err;
  // Reference model: game state, expected tick timestamps and difficulty level.
  int cyc, m_state, m_level, m_me, clr_age, next_tick, prev_hund;
  bit m_tick;
  bit hist[$];
  int last_tick, spacing, tick_count;

  function automatic int period(input int lv);
    return BASE_DIV - lv * DIV_STEP;
  endfunction

  function automatic logic [7:0] rnd_lo();
    logic [3:0] t, u;
    t = 4'($urandom_range(0, 9));
    u = 4'($urandom_range(0, 9));
    return {t, u};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},     16'(state),     16'(m_state));
    check({tag, ".game_tick"}, 16'(game_tick), 16'(m_tick));
    check({tag, ".game_rst"},  16'(game_rst),  16'(m_state == IDLE || m_state == CLEAR));
    check({tag, ".over"},      16'(over),      16'(m_state == OVER));
    check({tag, ".level"},     16'(level),     16'(m_level));
    check({tag, ".min_empty"}, 16'(min_empty), 16'(m_me));
  endtask

  task automatic model_reset();
    m_state = IDLE; m_tick = 1'b0; m_level = 0; m_me = ME_BASE;
    clr_age = 0; next_tick = 0; prev_hund = 0; cyc = 0;
    hist.delete();
  endtask

  // Apply inputs for the current cycle, advance the model, clock, then compare.
  task automatic step(input logic b, input logic c, input logic [15:0] s);
    bit press, n_tick;
    int n_state, n_level, hund;
    btn = b; collide = c; score = s;
    hund  = int'(s[11:8]);
    press = (cyc >= 3) && hist[cyc-2] && !hist[cyc-3];
    hist.push_back(b);
    n_state = m_state; n_tick = 1'b0; n_level = m_level;
    case (m_state)
      IDLE:    if (press) n_state = CLEAR;
      CLEAR:   if (clr_age == 1) n_state = RUN;
      RUN:     if (c) n_state = OVER;
      OVER:    if (press) n_state = CLEAR;
      default: ;
    endcase
    if (n_state == CLEAR) begin
      n_tick  = 1'b1;
      n_level = 0;
      clr_age = (m_state == CLEAR) ? 1 : 0;
    end else if (n_state == RUN) begin
      if (m_state == CLEAR) next_tick = cyc + 1 + BASE_DIV;
      else if (cyc + 1 == next_tick) begin
        n_tick = 1'b1;
        next_tick += period(m_level);
      end
    end
    if (m_state == RUN && !c && hund != prev_hund && m_level < MAX_LEVEL) n_level = m_level + 1;
    m_me = ME_BASE - ME_STEP * m_level;
    prev_hund = hund; m_state = n_state; m_tick = n_tick; m_level = n_level;
    cyc++;
    @(posedge clk); #1;
    check_all("cyc");
    if (game_tick === 1'b1) begin
      tick_count++;
      if (last_tick >= 0) spacing = cyc - last_tick;
      last_tick = cyc;
    end
  endtask

  task automatic do_reset(input logic b_hold);
    btn = b_hold; collide = 1'b0; score = 16'h0000;
    rst = 1'b0; #1;
    model_reset();
    check_all("reset");
    #2; rst = 1'b1;
    last_tick = -1; spacing = 0; tick_count = 0;
  endtask

  initial begin
    logic [15:0] sc;
    logic [3:0]  h, th;
    int cut;
    n_vec = 0; n_err = 0; last_tick = -1; spacing = 0; tick_count = 0;
    btn = 1'b0; collide = 1'b0; score = 16'h0000; rst = 1'b1;
    #1; do_reset(1'b0);

    // Start: press, CLEAR with two ticks, then RUN with ticks every BASE_DIV clk.
    repeat (3) step(1'b0, 1'b0, 16'h0000);
    repeat (6) step(1'b1, 1'b0, 16'h0000);
    repeat (30) step(1'b0, 1'b0, {8'h00, rnd_lo()});
    check("run_period_l0", 16'(spacing), 16'(BASE_DIV));

    // Hundreds 0->1: level 1, min_empty 280, period 9 from the next reload.
    repeat ($urandom_range(1, 9)) step(1'b0, 1'b0, 16'h0099);
    repeat (25) step(1'b0, 1'b0, {8'h01, rnd_lo()});
    check("run_period_l1", 16'(spacing), 16'(period(1)));
    check("min_empty_l1", 16'(min_empty), 16'(280));

    // Collide together with 0199->0200: OVER wins, level held, no ticks for 100 clk.
    repeat ($urandom_range(2, 8)) step(1'b0, 1'b0, 16'h0199);
    step(1'b0, 1'b1, 16'h0200);
    tick_count = 0;
    repeat (100) step(1'b0, 1'($urandom_range(0, 1)), {4'h0, 4'($urandom_range(0, 9)), rnd_lo()});
    check("over_ticks", 16'(tick_count), 16'(0));
    check("over_level", 16'(level), 16'(1));

    // Restart from OVER, then ten hundreds changes to saturate the level.
    repeat (6) step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    h = 4'd0; th = 4'd0;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(3, 12)) step(1'b0, 1'b0, {th, h, rnd_lo()});
      if (h == 4'd9) begin h = 4'd0; th = th + 4'd1; end
      else h = h + 4'd1;
    end
    repeat (30) step(1'b0, 1'b0, {th, h, rnd_lo()});
    check("sat_level", 16'(level), 16'(7));
    check("sat_min_empty", 16'(min_empty), 16'(160));
    check("sat_period", 16'(spacing), 16'(3));

    // Random collision time, restart, then reset on the first CLEAR tick with btn held.
    repeat ($urandom_range(1, 20)) step(1'b0, 1'b0, {th, h, rnd_lo()});
    step(1'b0, 1'b1, {th, h, 8'h00});
    repeat (5) step(1'b0, 1'b0, {th, h, 8'h00});
    cut = 0;
    while (m_state != CLEAR && cut < 10) begin
      step(1'b1, 1'b0, 16'h0000);
      cut++;
    end
    check("clear_reached", 16'(state), 16'(CLEAR));
    check("clear_tick", 16'(game_tick), 16'(1));
    do_reset(1'b1);
    repeat (12) step(1'b1, 1'b0, 16'h0000);
    check("held_btn_idle", 16'(state), 16'(IDLE));
    repeat (3) step(1'b0, 1'b0, 16'h0000);
    repeat (6) step(1'b1, 1'b0, 16'h0000);
    repeat (25) step(1'b0, 1'b0, {8'h00, rnd_lo()});
    check("restart_run", 16'(state), 16'(RUN));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
